// File: rtl/adc_snap_ctrl.sv
// ADC snapshot controller: arms on ctrl_arm rising edge, captures 2^ADDR_W samples after a trigger.
// Optional macro SNAP_TRIG_TIMEOUT_EN forces a capture after TIMEOUT cycles spent armed.
module adc_snap_ctrl #(
    parameter int          ADDR_W  = 10,
    parameter int          DATA_W  = 32,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic              user_clk,
    input  logic              user_rst,
    input  logic              ctrl_arm,
    input  logic              trig,
    input  logic              din_valid,
    input  logic [DATA_W-1:0] din,
    output logic              snap_we,
    output logic [ADDR_W-1:0] snap_addr,
    output logic [DATA_W-1:0] snap_data,
    output logic [31:0]       status
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_arm_d;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W:0]     r_wcnt;
    logic [7:0]          r_seq;

    logic                w_arm;
    logic                w_rearm;
    logic                w_force;
    logic                w_start;
    logic                w_accept;
    logic                w_last;
    logic [ADDR_W-1:0]   w_wr_addr;
    logic [ADDR_W:0]     w_wcnt_nxt;
    logic [7:0]          w_seq_nxt;
    logic                w_forced_nxt;
    logic [15:0]         w_wcnt_ext;

    assign w_arm   = ctrl_arm & ~r_arm_d;
    assign w_rearm = w_arm & ((r_state == S_IDLE) | (r_state == S_DONE));

`ifdef SNAP_TRIG_TIMEOUT_EN
    logic [31:0] r_tmo_cnt;
    logic        r_forced;

    // Counter restarts whenever the FSM leaves ARMED and saturates at TIMEOUT.
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            r_tmo_cnt <= '0;
            r_forced  <= 1'b0;
        end else begin
            if (r_state != S_ARMED)
                r_tmo_cnt <= '0;
            else if (r_tmo_cnt != TIMEOUT)
                r_tmo_cnt <= r_tmo_cnt + 32'd1;
            r_forced <= w_forced_nxt;
        end
    end

    assign w_force      = (r_tmo_cnt == TIMEOUT);
    assign w_forced_nxt = w_rearm ? 1'b0 : ((w_start & ~trig) ? 1'b1 : r_forced);
`else
    assign w_force      = 1'b0;
    assign w_forced_nxt = 1'b0;
`endif

    always_ff @(posedge user_clk) begin
        if (user_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_arm) w_state_nxt = S_ARMED;
            S_ARMED:   if (w_start) w_state_nxt = S_CAPTURE;
            S_CAPTURE: if (w_accept && w_last) w_state_nxt = S_DONE;
            S_DONE:    if (w_arm) w_state_nxt = S_ARMED;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_start    = (r_state == S_ARMED) & din_valid & (trig | w_force);
        w_accept   = w_start | ((r_state == S_CAPTURE) & din_valid);
        w_wr_addr  = w_start ? '0 : r_addr;
        w_last     = (w_wr_addr == {ADDR_W{1'b1}});
        w_wcnt_nxt = w_rearm ? '0 : (w_accept ? r_wcnt + 1'b1 : r_wcnt);
        w_seq_nxt  = ((r_state == S_CAPTURE) && w_accept && w_last) ? r_seq + 8'd1 : r_seq;
        w_wcnt_ext = 16'(w_wcnt_nxt);
    end

    // Status is built from next-state values so it lines up with the state register.
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            r_arm_d   <= 1'b1;
            snap_we   <= 1'b0;
            snap_addr <= '0;
            snap_data <= '0;
            r_addr    <= '0;
            r_wcnt    <= '0;
            r_seq     <= '0;
            status    <= '0;
        end else begin
            r_arm_d <= ctrl_arm;
            snap_we <= w_accept;
            if (w_accept) begin
                snap_addr <= w_wr_addr;
                snap_data <= din;
                r_addr    <= w_wr_addr + 1'b1;
            end
            r_wcnt <= w_wcnt_nxt;
            r_seq  <= w_seq_nxt;
            status <= {w_state_nxt == S_DONE, w_state_nxt == S_ARMED,
                       w_state_nxt == S_CAPTURE, w_forced_nxt, 4'b0000,
                       w_seq_nxt, w_wcnt_ext};
        end
    end

endmodule

// File: tb/tb_adc_snap_ctrl.sv
// Directed bench for adc_snap_ctrl with a write scoreboard (ADDR_W=4, TIMEOUT=100).
module tb_adc_snap_ctrl;

    localparam int AW = 4;
    localparam int DW = 32;

    logic          user_clk = 1'b0;
    logic          user_rst = 1'b1;
    logic          ctrl_arm = 1'b0;
    logic          trig = 1'b0;
    logic          din_valid = 1'b0;
    logic [DW-1:0] din = '0;
    logic          snap_we;
    logic [AW-1:0] snap_addr;
    logic [DW-1:0] snap_data;
    logic [31:0]   status;

    adc_snap_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(100)) dut (
        .user_clk (user_clk),
        .user_rst (user_rst),
        .ctrl_arm (ctrl_arm),
        .trig     (trig),
        .din_valid(din_valid),
        .din      (din),
        .snap_we  (snap_we),
        .snap_addr(snap_addr),
        .snap_data(snap_data),
        .status   (status)
    );

    always #5 user_clk = ~user_clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always @(posedge user_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Every write the DUT produces must match the oldest expected write, in the expected cycle.
    always @(negedge user_clk) begin
        if (snap_we === 1'b1) begin
            if (sb.size() == 0) begin
                check("write_expected", {31'b0, snap_we}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("write_addr", {28'b0, snap_addr}, e.addr);
                check("write_data", snap_data, e.data);
                check("write_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge user_clk);
        #1;
    endtask

    task automatic push(input int addr, input logic [31:0] data);
        exp_t e;
        e.addr = addr;
        e.data = data;
        e.cyc  = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic do_arm();
        ctrl_arm = 1'b1;
        tick();
        ctrl_arm = 1'b0;
    endtask

    task automatic capture(input bit gapped, input logic [31:0] base, input int arm_at,
                           input logic [7:0] seq);
        for (int i = 0; i < 16; i++) begin
            if (gapped && i > 0) begin
                din_valid = 1'b0;
                trig      = 1'b0;
                din       = 32'hBAD0_0000 + i;
                tick();
            end
            din_valid = 1'b1;
            trig      = (i == 0);
            ctrl_arm  = (i == arm_at);
            din       = base + i;
            push(i, base + i);
            tick();
            ctrl_arm = 1'b0;
            if (i == 1)
                check("status_capturing", status, {8'h20, seq, 16'd2});
        end
        din_valid = 1'b0;
        trig      = 1'b0;
        tick();
    endtask

    initial begin
        logic [7:0] seq;
        seq = 8'd0;

        // Reset state
        repeat (3) tick();
        check("rst_we", {31'b0, snap_we}, 32'd0);
        check("rst_addr", {28'b0, snap_addr}, 32'd0);
        check("rst_data", snap_data, 32'd0);
        check("rst_status", status, 32'd0);
        user_rst = 1'b0;
        tick();

        // Trigger with valid while idle is ignored
        trig = 1'b1;
        din_valid = 1'b1;
        din = 32'h1234;
        repeat (4) tick();
        trig = 1'b0;
        din_valid = 1'b0;
        tick();
        check("idle_trig_status", status, 32'd0);

        // Basic continuous capture
        do_arm();
        check("arm_status", status, 32'h4000_0000);
        capture(1'b0, 32'd0, -1, seq);
        seq++;
        check("basic_done_status", status, 32'h8001_0010);

        // Gapped valid with an arm pulse during capture
        tick();
        do_arm();
        check("rearm_status", status, 32'h4001_0000);
        capture(1'b1, 32'h100, 5, seq);
        seq++;
        check("gapped_done_status", status, 32'h8002_0010);

        // Valid + trig in DONE produces no write
        din_valid = 1'b1;
        trig = 1'b1;
        repeat (3) tick();
        din_valid = 1'b0;
        trig = 1'b0;
        tick();
        check("done_hold_status", status, 32'h8002_0010);

        // Re-arm until the sequence counter wraps
        for (int n = 0; n < 254; n++) begin
            do_arm();
            check("wrap_arm_status", status, {8'h40, seq, 16'd0});
            capture(1'b0, 32'h1000 * (n + 1), -1, seq);
            seq++;
            tick();
        end
        check("wrap_done_status", status, 32'h8000_0010);

        // Reset in the cycle write 7 is on the bus
        do_arm();
        for (int i = 0; i < 8; i++) begin
            din_valid = 1'b1;
            trig = (i == 0);
            din = 32'hC0DE_0000 + i;
            push(i, 32'hC0DE_0000 + i);
            tick();
        end
        check("midrst_write7_we", {31'b0, snap_we}, 32'd1);
        user_rst = 1'b1;
        ctrl_arm = 1'b1;
        trig = 1'b1;
        tick();
        check("midrst_we", {31'b0, snap_we}, 32'd0);
        check("midrst_status", status, 32'd0);
        tick();
        user_rst = 1'b0;
        repeat (5) tick();
        check("arm_high_release_status", status, 32'd0);
        ctrl_arm = 1'b0;
        trig = 1'b0;
        din_valid = 1'b0;
        tick();

`ifdef SNAP_TRIG_TIMEOUT_EN
        // Forced trigger after 100 armed cycles
        do_arm();
        repeat (99) tick();
        din_valid = 1'b1;
        din = 32'hEEEE_0000;
        tick();
        check("tmo_early_status", status, 32'h4000_0000);
        for (int i = 0; i < 16; i++) begin
            din = 32'hF000_0000 + i;
            push(i, 32'hF000_0000 + i);
            tick();
        end
        din_valid = 1'b0;
        tick();
        check("tmo_done_status", status, 32'h9001_0010);
`else
        // Without the timeout, ARMED waits indefinitely
        do_arm();
        din_valid = 1'b1;
        din = 32'hEEEE_0000;
        repeat (1000) tick();
        din_valid = 1'b0;
        tick();
        check("no_tmo_status", status, 32'h4000_0000);
`endif

        repeat (2) tick();
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/adc_snap_ctrl.md
ADC_SNAP_CTRL -- requirements
Module: adc_snap_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning snapshot buffer depth 2^ADDR_W words (legal 4..15).
REQ-002 SHALL have parameter DATA_W, default 32, meaning sample width.
REQ-003 SHALL have parameter TIMEOUT, default 65535, meaning the ARMED-state cycle limit for a forced trigger (used only with SNAP_TRIG_TIMEOUT_EN).
REQ-004 SHALL have port user_clk, input, 1, the single clock; all logic is rising-edge.
REQ-005 SHALL have port user_rst, input, 1, reset, synchronous, active-high.
REQ-006 SHALL have port ctrl_arm, input, 1, arm request from the software control register; its rising edge is the arm event.
REQ-007 SHALL have port trig, input, 1, capture trigger, level-qualified.
REQ-008 SHALL have port din_valid, input, 1, sample valid strobe.
REQ-009 SHALL have port din, input, DATA_W, ADC sample.
REQ-010 SHALL have port snap_we, output, 1, buffer write enable.
REQ-011 SHALL have port snap_addr, output, ADDR_W, buffer write address.
REQ-012 SHALL have port snap_data, output, DATA_W, buffer write data.
REQ-013 SHALL have port status, output, 32, status word driving the simulink2ppc status register user_data_in.

Function
REQ-014 SHALL implement the states IDLE, ARMED, CAPTURE and DONE.
REQ-015 SHALL detect arm as ctrl_arm high with a registered ctrl_arm low on the previous cycle.
REQ-016 IDLE SHALL go to ARMED on arm, and DONE SHALL go to ARMED on arm, clearing the done flag; arm SHALL be ignored in ARMED and CAPTURE.
REQ-017 ARMED SHALL go to CAPTURE when trig=1 and din_valid=1 in the same cycle, and that sample SHALL be written at address 0.
REQ-018 trig SHALL be ignored in IDLE, CAPTURE and DONE; arm and trig coinciding in IDLE SHALL only arm.
REQ-019 In CAPTURE, each din_valid=1 cycle SHALL write one sample at the next address; din_valid=0 cycles SHALL write nothing.
REQ-020 snap_we/snap_addr/snap_data SHALL be registered, appearing exactly 1 cycle after the accepted din_valid/din cycle.
REQ-021 After the write to address 2^ADDR_W-1, the state SHALL be DONE and the address SHALL NOT wrap into further writes.
REQ-022 The word count SHALL be ADDR_W+1 bits, equal 0 on arm and 2^ADDR_W in DONE.
REQ-023 The capture sequence counter SHALL be 8 bits, increment on each entry to DONE, and wrap 255->0.
REQ-024 status[31]=done, [30]=armed, [29]=capturing, [28]=forced-trigger flag, [27:24]=0, [23:16]=sequence counter, [15:0]=word count zero-extended; status SHALL be registered.
REQ-025 snap_we SHALL be 0 in every cycle not covered by REQ-019/REQ-020.

Reset
REQ-026 user_rst SHALL set state IDLE, snap_we=0, snap_addr=0, snap_data=0, status=0, word count 0, sequence counter 0, forced flag 0, and the registered ctrl_arm 1, so that a level already high at reset release is not an arm event.
REQ-027 Reset asserted mid-CAPTURE SHALL abort the capture with no further writes from the next cycle and no DONE entry.

Configuration
REQ-028 With macro SNAP_TRIG_TIMEOUT_EN defined, a counter SHALL run in ARMED, and on reaching TIMEOUT cycles the next din_valid=1 cycle SHALL start CAPTURE as though triggered, setting status[28]=1 until the next arm.
REQ-029 Without SNAP_TRIG_TIMEOUT_EN, no timeout logic SHALL exist, ARMED SHALL wait indefinitely, and status[28] SHALL be constant 0.

Verification
REQ-030 The bench SHALL cover basic capture: ADDR_W=4, arm, trig+valid with din=0..15 continuous -> 16 writes at addr 0..15 one cycle delayed, status=0x8001_0010.
REQ-031 The bench SHALL cover gapped valid: din_valid toggling 1/0 during CAPTURE -> exactly 16 writes, never two per valid, DONE after the 16th.
REQ-032 The bench SHALL cover ignored events: trig while IDLE, arm pulse during CAPTURE -> no state change, capture completes normally.
REQ-033 The bench SHALL cover re-arm and wrap: 256 arm/capture cycles -> sequence counter 0x00 and done cleared on each arm (status[31]=0, [30]=1).
REQ-034 The bench SHALL cover reset mid-capture: user_rst at write 7 -> snap_we=0 from the next cycle and status=0; ctrl_arm held high through release -> stays IDLE.
REQ-035 The bench SHALL cover timeout with SNAP_TRIG_TIMEOUT_EN defined: TIMEOUT=100, no trig -> capture starts on the first valid after 100 ARMED cycles and status[28]=1; without the macro it stays ARMED after 1000 cycles.
